// File: rtl/run_length_detector.sv
// run_length_detector
//   Flags when the same W-bit symbol has been seen on RUN_LEN consecutive
//   valid samples. Runs may be counted overlapping or non-overlapping, and
//   may optionally be restricted to a single target symbol. All outputs are
//   registered; a hit shows up on the edge that samples the qualifying x.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid       x is a sample this cycle (gaps hold the run)
//   x              input symbol
//   non_overlap    0: every sample at/after RUN_LEN hits, 1: hit every RUN_LEN
//   target_en      restrict hits to runs of target
//   target         symbol to match when target_en=1
//   hit_clr        synchronous clear of hit_cnt (wins over a same-cycle hit)
//   y              registered one-cycle-per-hit flag
//   run_len        length of the current run, saturating
//   run_sym        symbol of the current run
//   hit_cnt        saturating hit counter
module run_length_detector #(
    parameter int W       = 1,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8,
    parameter int HIT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     x,
    input  logic             non_overlap,
    input  logic             target_en,
    input  logic [W-1:0]     target,
    input  logic             hit_clr,
    output logic             y,
    output logic [CNT_W-1:0] run_len,
    output logic [W-1:0]     run_sym,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] RL      = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   ph, ph_n;
    logic [CNT_W-1:0]   run_len_n;
    logic [W-1:0]       run_sym_n;
    logic [HIT_W-1:0]   hit_cnt_n;
    logic               y_n;

    logic               new_run, sym_ok, hit;
    logic [CNT_W-1:0]   n, p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            y       <= 1'b0;
            run_len <= '0;
            run_sym <= '0;
            ph      <= '0;
            hit_cnt <= '0;
        end else begin
            state   <= state_n;
            y       <= y_n;
            run_len <= run_len_n;
            run_sym <= run_sym_n;
            ph      <= ph_n;
            hit_cnt <= hit_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        y_n       = 1'b0;
        run_len_n = run_len;
        run_sym_n = run_sym;
        ph_n      = ph;
        hit_cnt_n = hit_cnt;

        // Candidate run length / phase if the current x is accepted.
        new_run = (state == IDLE) || (x != run_sym);
        n       = new_run ? ONE : ((run_len == LEN_MAX) ? LEN_MAX : run_len + ONE);
        p       = new_run ? ONE : ((ph >= RL) ? RL : ph + ONE);
        sym_ok  = !target_en || (x == target);
        hit     = sym_ok && (non_overlap ? (p == RL) : (n >= RL));

        if (in_valid) begin
            state_n   = RUN;
            run_sym_n = x;
            run_len_n = n;
            y_n       = hit;
            // Non-overlap restarts the phase after each hit so the next hit
            // needs a fresh RUN_LEN samples; overlap keeps p saturated.
            ph_n      = (non_overlap && hit) ? '0 : p;
            if (hit && (hit_cnt != HIT_MAX))
                hit_cnt_n = hit_cnt + HIT_W'(1);
        end

        if (hit_clr)
            hit_cnt_n = '0;
    end

endmodule

// File: doc/run_length_detector.md
# run_length_detector

Parametrised run detector for a sampled symbol stream. It asserts a registered flag whenever the same symbol has been seen on `RUN_LEN` consecutive valid samples. It generalises the fixed 1-bit "111 / 000" detector to W-bit symbols, any run length, an optional target symbol, and overlapping or non-overlapping counting. It sits directly on a sampled input stream and feeds control logic and a saturating hit counter for status readback.

## Interface
- `W`, 1, symbol width in bits.
- `RUN_LEN`, 3, consecutive identical samples needed for a hit; legal range 1 .. 2^CNT_W-1.
- `CNT_W`, 8, width of the run-length counter.
- `HIT_W`, 16, width of the hit counter.

- `clk`  in  1  clock, all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  current `x` is a sample; when low, `x` is ignored.
- `x`  in  W  input symbol.
- `non_overlap`  in  1  0 = overlapping runs, 1 = non-overlapping runs.
- `target_en`  in  1  1 = only runs of `target` count; 0 = runs of any symbol count.
- `target`  in  W  symbol to match when `target_en`=1.
- `hit_clr`  in  1  synchronous clear of `hit_cnt`.
- `y`  out  1  registered hit flag.
- `run_len`  out  CNT_W  length of the current run, saturating.
- `run_sym`  out  W  symbol of the current run.
- `hit_cnt`  out  HIT_W  number of hits, saturating.

## Operation
- States: IDLE (no valid sample since reset) and RUN.
- Reset values: state=IDLE, `y`=0, `run_len`=0, `run_sym`=0, phase counter `ph`=0, `hit_cnt`=0.
- Behaviour on an accepted sample (`in_valid`=1):
  - **IDLE, or `x` != `run_sym`:** new run. `run_sym`<=`x`, n=1, state<=RUN.
  - **Otherwise:** n = `run_len`+1, saturating at 2^CNT_W-1.
  - `run_len`<=n.
  - sym_ok = !`target_en` || (`x`==`target`). Evaluated with the current `target`/`target_en`.
  - Phase: new run -> p=1; same symbol -> p=min(`ph`+1, RUN_LEN).
  - **Overlap mode:** hit = sym_ok && n>=RUN_LEN. A run of k samples produces k-RUN_LEN+1 hits.
  - **Non-overlap mode:** hit = sym_ok && p==RUN_LEN. On a hit, `ph`<=0; otherwise `ph`<=p. A run of k samples produces floor(k/RUN_LEN) hits.
  - In overlap mode, `ph`<=p (no clear on hit).
  - `y`<=hit.
  - If hit and `hit_cnt` is not at its maximum, `hit_cnt`<=`hit_cnt`+1.
- Cycles with `in_valid`=0:
  - `y`<=0.
  - Run state, `run_len`, `run_sym` and `ph` hold. Gaps do not break a run.
- Boundary behaviour:
  - `run_len` saturated: stays at max. Overlap mode keeps hitting while the run continues.
  - `non_overlap` or `target` changes mid-run: takes effect at the next accepted sample. The run and `ph` are not reset.
  - RUN_LEN=1: every accepted sample with sym_ok hits, in both modes.
  - `hit_clr` together with a hit: the clear wins and `hit_cnt`=0.
  - `rst` overrides everything, including mid-run and `hit_clr`.

## Timing
- Latency is one cycle. `y`, `run_len`, `run_sym` and `hit_cnt` change at the rising edge that samples the qualifying `x`.
- `y` is a one-cycle-per-hit pulse. It stays high across consecutive valid hit cycles.
- All outputs are registered. There is no combinational input-to-output path.
- First valid sample after `rst` deasserts:
  - Reset is synchronous, so the first valid sample can be on the cycle after `rst`=1 is sampled.
  - That sample starts a run with `run_len`=1.

## Test plan
Unless stated otherwise: W=1, RUN_LEN=3, `target_en`=0.

1. **Overlapping runs.** Overlap mode; valid x = 1,1,1,1,1,0,0,0,1 -> `y` high after samples 3, 4, 5 and 8, low elsewhere; `hit_cnt`=4; `run_len` sequence = 1,2,3,4,5,1,2,3,1.
2. **Non-overlapping runs.** Non-overlap mode; x = 1 for six samples, then 0 -> hits after samples 3 and 6 only; `hit_cnt`=2.
3. **Target filter.** `target_en`=1, `target`=0; x = 1,1,1,0,0,0,0 -> no hit on the ones; hits after samples 6 and 7 (overlap mode).
4. **Valid gaps and mid-run reset.**
   - x = 1,1 valid, two cycles with `in_valid`=0, then 1 valid -> `y`=0 during the gap, `y`=1 after the third valid sample.
   - Then assert `rst` for one cycle and send 1,1 -> no hit; `run_len`=2.
5. **Saturation.**
   - CNT_W=3, 9 consecutive ones in overlap mode -> `run_len` stops at 7; `y` stays high from sample 3 through 9; `hit_cnt`=7.
   - HIT_W=2 -> `hit_cnt` holds at 3.
   - `hit_clr` asserted on the same cycle as a hit -> `hit_cnt`=0.
6. **Wide symbols.** W=4, RUN_LEN=2, non-overlap mode; x = A,A,A,A,5,5,A -> hits after samples 2, 4 and 6; `run_sym`=A at the end.
